// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the ID->EX operand-fetch stage.
package operand_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;
  localparam int NREG   = 32;

  typedef logic [4:0] regidx_t;

  localparam regidx_t ZERO_REG = 5'd0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the operand-fetch stage.
interface operand_fetch_if #(
  parameter int XLEN   = operand_fetch_pkg::XLEN,
  parameter int CTRL_W = operand_fetch_pkg::CTRL_W
);

  // decode side
  logic                      in_valid;
  logic                      in_ready;
  operand_fetch_pkg::regidx_t in_rs1;
  operand_fetch_pkg::regidx_t in_rs2;
  operand_fetch_pkg::regidx_t in_rd;
  logic                      in_regwrite;
  logic [XLEN-1:0]           in_pc;
  logic [XLEN-1:0]           in_imm;
  logic [CTRL_W-1:0]         in_ctrl;

  // register file and writeback
  operand_fetch_pkg::regidx_t rf_rs1;
  operand_fetch_pkg::regidx_t rf_rs2;
  logic [XLEN-1:0]           rf_rd1;
  logic [XLEN-1:0]           rf_rd2;
  logic                      wb_regwrite;
  operand_fetch_pkg::regidx_t wb_rd;
  logic [XLEN-1:0]           wb_dat;

  // execute side
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_rs1_val;
  logic [XLEN-1:0]           out_rs2_val;
  operand_fetch_pkg::regidx_t out_rd;
  logic                      out_regwrite;
  logic [XLEN-1:0]           out_pc;
  logic [XLEN-1:0]           out_imm;
  logic [CTRL_W-1:0]         out_ctrl;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_regwrite, in_pc, in_imm, in_ctrl,
    input  rf_rd1, rf_rd2, wb_regwrite, wb_rd, wb_dat, flush, out_ready,
    output in_ready, rf_rs1, rf_rs2,
    output out_valid, out_rs1_val, out_rs2_val, out_rd, out_regwrite, out_pc, out_imm, out_ctrl
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_regwrite, in_pc, in_imm, in_ctrl,
    output rf_rd1, rf_rd2, wb_regwrite, wb_rd, wb_dat, flush, out_ready,
    input  in_ready, rf_rs1, rf_rs2,
    input  out_valid, out_rs1_val, out_rs2_val, out_rd, out_regwrite, out_pc, out_imm, out_ctrl
  );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-destination bitmap: one bit per architectural register written by an
// instruction that has issued but not yet written back. Bit 0 never sets.
module opfetch_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int NREG = operand_fetch_pkg::NREG
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    set_en,
  input  regidx_t set_idx,
  input  logic    clr_wb_en,
  input  regidx_t clr_wb_idx,
  input  logic    clr_fl_en,
  input  regidx_t clr_fl_idx,
  input  regidx_t rs1,
  input  regidx_t rs2,
  input  regidx_t rd,
  output logic    pend_rs1,
  output logic    pend_rs2,
  output logic    pend_rd
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  assign set_vec = set_en ? (NREG'(1) << set_idx) : '0;
  assign clr_vec = (clr_wb_en ? (NREG'(1) << clr_wb_idx) : '0)
                 | (clr_fl_en ? (NREG'(1) << clr_fl_idx) : '0);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      // set applied after clear so a same-cycle reissue keeps the bit
      pending <= ((pending & ~clr_vec) | set_vec) & ~NREG'(1);
    end
  end

  assign pend_rs1 = pending[rs1];
  assign pend_rs2 = pending[rs2];
  assign pend_rd  = pending[rd];

endmodule

// File: rtl/operand_fetch.sv
// ID->EX operand fetch: regfile read, writeback bypass, scoreboard stall, one-entry
// output slot. Define OPFETCH_BYPASS_EN to forward same-cycle writeback data.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN   = operand_fetch_pkg::XLEN,
  parameter int CTRL_W = operand_fetch_pkg::CTRL_W,
  parameter int NREG   = operand_fetch_pkg::NREG
) (
  input logic             clk,
  input logic             reset,
  operand_fetch_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    regidx_t           rd;
    logic              regwrite;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  slot_state_t     state;
  payload_t        slot;
  logic            byp1, byp2;
  logic [XLEN-1:0] op1, op2;
  logic            pend_rs1, pend_rs2, pend_rd;
  logic            raw1, raw2, waw, hazard;
  logic            fire, drain;

  assign bus.rf_rs1 = bus.in_rs1;
  assign bus.rf_rs2 = bus.in_rs2;

`ifdef OPFETCH_BYPASS_EN
  assign byp1 = bus.wb_regwrite && (bus.wb_rd == bus.in_rs1);
  assign byp2 = bus.wb_regwrite && (bus.wb_rd == bus.in_rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op1 = bus.rf_rd1;
    op2 = bus.rf_rd2;
    if (byp1) op1 = bus.wb_dat;
    if (byp2) op2 = bus.wb_dat;
    if (bus.in_rs1 == ZERO_REG) op1 = '0;
    if (bus.in_rs2 == ZERO_REG) op2 = '0;
  end

  // a bypass hit resolves RAW because the producer's data is on wb_dat right now
  assign raw1   = (bus.in_rs1 != ZERO_REG) && pend_rs1 && !byp1;
  assign raw2   = (bus.in_rs2 != ZERO_REG) && pend_rs2 && !byp2;
  assign waw    = bus.in_regwrite && (bus.in_rd != ZERO_REG) && pend_rd;
  assign hazard = raw1 || raw2 || waw;

  assign bus.in_ready = ((state == SLOT_EMPTY) || bus.out_ready) && !hazard && !bus.flush;
  assign fire         = bus.in_valid && bus.in_ready;
  assign drain        = (state == SLOT_FULL) && bus.out_ready;

  opfetch_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (fire && bus.in_regwrite && (bus.in_rd != ZERO_REG)),
    .set_idx    (bus.in_rd),
    .clr_wb_en  (bus.wb_regwrite),
    .clr_wb_idx (bus.wb_rd),
    .clr_fl_en  (bus.flush && (state == SLOT_FULL) && slot.regwrite && (slot.rd != ZERO_REG)),
    .clr_fl_idx (slot.rd),
    .rs1        (bus.in_rs1),
    .rs2        (bus.in_rs2),
    .rd         (bus.in_rd),
    .pend_rs1   (pend_rs1),
    .pend_rs2   (pend_rs2),
    .pend_rd    (pend_rd)
  );

  // NOTE: the payload flops are reset along with the state so out_* read zero
  // after reset rather than X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SLOT_EMPTY;
      slot  <= '0;
    end else begin
      unique case (state)
        SLOT_EMPTY: if (fire) state <= SLOT_FULL;
        SLOT_FULL:  if (bus.flush || (drain && !fire)) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      if (fire) begin
        slot.rs1_val  <= op1;
        slot.rs2_val  <= op2;
        slot.rd       <= bus.in_rd;
        slot.regwrite <= bus.in_regwrite;
        slot.pc       <= bus.in_pc;
        slot.imm      <= bus.in_imm;
        slot.ctrl     <= bus.in_ctrl;
      end
    end
  end

  assign bus.out_valid    = (state == SLOT_FULL);
  assign bus.out_rs1_val  = slot.rs1_val;
  assign bus.out_rs2_val  = slot.rs2_val;
  assign bus.out_rd       = slot.rd;
  assign bus.out_regwrite = slot.regwrite;
  assign bus.out_pc       = slot.pc;
  assign bus.out_imm      = slot.imm;
  assign bus.out_ctrl     = slot.ctrl;

endmodule
